// File: rtl/cpu_core_mc_if.sv
// Memory-side bus of cpu_core_mc: combinational instruction port plus a
// request/ready data-memory handshake. master = core, slave = memories.
interface cpu_core_mc_if #(
  parameter int DATA_W  = 8,
  parameter int PC_W    = 8,
  parameter int DADDR_W = 8
);
  logic [PC_W-1:0]    imem_addr;
  logic [15:0]        imem_data;
  logic               dmem_req;
  logic               dmem_we;
  logic [DADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0]  dmem_wdata;
  logic [DATA_W-1:0]  dmem_rdata;
  logic               dmem_ready;

  modport master (
    output imem_addr,
    input  imem_data,
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    input  dmem_rdata,
    input  dmem_ready
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    output dmem_rdata,
    output dmem_ready
  );
endinterface

// File: rtl/cpu_core_mc.sv
// cpu_core_mc: multi-cycle 16-bit-ISA core, FETCH/DECODE/EXECUTE/MEM/WB
// plus an absorbing HALT state. 16 x DATA_W register file, R0 reads zero.
// Optional instruction-retire trace ports are built when CPU_TRACE_EN is
// defined; without it the core has no trace ports and no fetch-address copy.
// The interface instance connected to bus must use the same DATA_W/PC_W/DADDR_W.
module cpu_core_mc #(
  parameter int DATA_W  = 8,
  parameter int PC_W    = 8,
  parameter int DADDR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  cpu_core_mc_if.master    bus,
  output logic             halted,
  output logic [2:0]       state_dbg,
  output logic [PC_W-1:0]  pc_dbg,
  output logic [15:0]      ir_dbg
`ifdef CPU_TRACE_EN
  ,
  output logic             retire_valid,
  output logic [PC_W-1:0]  retire_pc,
  output logic [15:0]      retire_ir
`endif
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_HALT    = 3'd5
  } state_t;

  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_LD   = 4'h7;
  localparam logic [3:0] OP_ST   = 4'h8;
  localparam logic [3:0] OP_BEQZ = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t              state_q, state_d;
  logic [PC_W-1:0]     pc;
  logic [15:0]         ir;
  logic [DATA_W-1:0]   regs [16];
  logic                flag_z, flag_c;

  // operands captured in DECODE, ALU result in EXECUTE, write-back value in MEM
  logic [DATA_W-1:0]   opa_p1, opb_p1, opd_p1;
  logic [DATA_W-1:0]   res_p2;
  logic                cout_p2;
  logic [DATA_W-1:0]   res_p3;

  logic [3:0] op, rd, rs, rt;
  logic [7:0] imm8;
  logic       is_mem, is_ld, writes_rd, sets_flags;

  assign op   = ir[15:12];
  assign rd   = ir[11:8];
  assign rs   = ir[7:4];
  assign rt   = ir[3:0];
  assign imm8 = ir[7:0];

  assign is_ld      = (op == OP_LD);
  assign is_mem     = (op == OP_LD) || (op == OP_ST);
  assign writes_rd  = (op >= OP_LDI) && (op <= OP_LD);
  assign sets_flags = (op >= OP_ADD) && (op <= OP_XOR);

  // Register read with R0 hard-wired to zero.
  function automatic logic [DATA_W-1:0] rd_reg(input logic [3:0] idx,
                                               input logic [DATA_W-1:0] val);
    return (idx == 4'd0) ? '0 : val;
  endfunction

  // ALU: {carry, result}. SUB carry is the unsigned borrow (a < b), which is
  // exactly the top bit of the (DATA_W+1)-bit difference.
  function automatic logic [DATA_W:0] alu_f(input logic [3:0] f_op,
                                            input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b,
                                            input logic [7:0] imm);
    logic [DATA_W:0] r;
    case (f_op)
      OP_LDI:  r = {1'b0, DATA_W'(imm)};
      OP_ADD:  r = {1'b0, a} + {1'b0, b};
      OP_SUB:  r = {1'b0, a} - {1'b0, b};
      OP_AND:  r = {1'b0, a & b};
      OP_OR:   r = {1'b0, a | b};
      OP_XOR:  r = {1'b0, a ^ b};
      default: r = '0;
    endcase
    return r;
  endfunction

  // Branch target: incremented pc plus sign-extended imm8, wrapping mod 2^PC_W.
  function automatic logic [PC_W-1:0] br_tgt_f(input logic [PC_W-1:0] cur_pc,
                                               input logic [7:0] imm);
    logic signed [7:0]      off;
    logic signed [PC_W+7:0] ext;
    off = imm;
    ext = {{PC_W{off[7]}}, off};
    return cur_pc + ext[PC_W-1:0];
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state sequencing; MEM stalls on LD/ST until dmem_ready.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:   state_d = S_DECODE;
      S_DECODE:  state_d = (op == OP_HALT) ? S_HALT : S_EXECUTE;
      S_EXECUTE: state_d = S_MEM;
      S_MEM:     state_d = (!is_mem || bus.dmem_ready) ? S_WB : S_MEM;
      S_WB:      state_d = S_FETCH;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_FETCH;
    endcase
  end

  // Architectural state: pc, ir, register file and flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc     <= '0;
      ir     <= '0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else begin
      case (state_q)
        S_FETCH: begin
          ir <= bus.imem_data;
          pc <= pc + 1'b1;
        end
        S_EXECUTE: begin
          if (op == OP_BEQZ && opd_p1 == '0) pc <= br_tgt_f(pc, imm8);
          else if (op == OP_JMP)             pc <= ir[PC_W-1:0];
        end
        S_WB: begin
          if (writes_rd && rd != 4'd0) regs[rd] <= res_p3;
          if (sets_flags) begin
            flag_z <= (res_p3 == '0);
            flag_c <= cout_p2;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath latches: operands (DECODE), ALU (EXECUTE), write-back value (MEM).
  always_ff @(posedge clk) begin
    // DECODE -> EXECUTE
    if (state_q == S_DECODE) begin
      opa_p1 <= rd_reg(rs, regs[rs]);
      opb_p1 <= rd_reg(rt, regs[rt]);
      opd_p1 <= rd_reg(rd, regs[rd]);
    end
    // EXECUTE -> MEM
    if (state_q == S_EXECUTE) begin
      {cout_p2, res_p2} <= alu_f(op, opa_p1, opb_p1, imm8);
    end
    // MEM -> WB; for LD the last MEM cycle is the ready cycle
    if (state_q == S_MEM) begin
      res_p3 <= is_ld ? bus.dmem_rdata : res_p2;
    end
  end

  assign bus.imem_addr  = pc;
  assign bus.dmem_req   = (state_q == S_MEM) && is_mem;
  assign bus.dmem_we    = (op == OP_ST);
  assign bus.dmem_addr  = opa_p1[DADDR_W-1:0];
  assign bus.dmem_wdata = opd_p1;

  assign halted    = (state_q == S_HALT);
  assign state_dbg = state_q;
  assign pc_dbg    = pc;
  assign ir_dbg    = ir;

`ifdef CPU_TRACE_EN
  logic [PC_W-1:0] fetch_pc;

  // Remember where the in-flight instruction was fetched from.
  always_ff @(posedge clk) begin
    if (reset)                  fetch_pc <= '0;
    else if (state_q == S_FETCH) fetch_pc <= pc;
  end

  assign retire_valid = (state_q == S_WB);
  assign retire_pc    = fetch_pc;
  assign retire_ir    = ir;
`endif

endmodule

// File: tb/tb_cpu_core_mc.sv
// Bench for cpu_core_mc: table of ALU programs plus hand-written programs
// for load stalls, branches/jumps, R0 behaviour and reset during a stall.
module tb_cpu_core_mc;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        halted;
  logic [2:0]  state_dbg;
  logic [7:0]  pc_dbg;
  logic [15:0] ir_dbg;

  cpu_core_mc_if #(.DATA_W(8), .PC_W(8), .DADDR_W(8)) bus ();

`ifdef CPU_TRACE_EN
  logic        retire_valid;
  logic [7:0]  retire_pc;
  logic [15:0] retire_ir;
`endif

  cpu_core_mc #(.DATA_W(8), .PC_W(8), .DADDR_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .halted    (halted),
    .state_dbg (state_dbg),
    .pc_dbg    (pc_dbg),
    .ir_dbg    (ir_dbg)
`ifdef CPU_TRACE_EN
    ,
    .retire_valid (retire_valid),
    .retire_pc    (retire_pc),
    .retire_ir    (retire_ir)
`endif
  );

  always #5 clk = ~clk;

  logic [15:0] prog [256];
  assign bus.imem_data = prog[bus.imem_addr];

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
  } txn_t;

  typedef struct {
    logic [3:0] op;
    logic [7:0] x, y, res;
    logic       c, z, c_care;
  } alu_vec_t;

  txn_t       sb [$];
  int         fetch_cyc [256];
  int         cyc;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] ld_val;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 16'hF000;
    sb.delete();
  endtask

  task automatic push_txn(input logic we, input logic [7:0] addr, input logic [7:0] data);
    txn_t t;
    t.we = we; t.addr = addr; t.data = data;
    sb.push_back(t);
  endtask

  // Reset the core, run the loaded program with a data memory that answers
  // after wait_cfg stall cycles, and check scoreboard/halt behaviour.
  // abort_req>0: assert reset during the abort_req-th request cycle instead.
  task automatic run_prog(input int wait_cfg, input bit idle_ready, input int abort_req);
    int         wcnt, reqcyc;
    bit         stable, done, bad;
    logic       f_we;
    logic [7:0] f_addr, f_wdata, p;
    txn_t       e;
    for (int i = 0; i < 256; i++) fetch_cyc[i] = -1;
    reset = 1'b1;
    bus.dmem_ready = 1'b0;
    bus.dmem_rdata = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
    chk("rst_state", 32'(state_dbg), 32'd0);
    chk("rst_pc", 32'(pc_dbg), 32'd0);
    chk("rst_ir", 32'(ir_dbg), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_req", 32'(bus.dmem_req), 32'd0);
    wcnt = 0; reqcyc = 0; stable = 1'b1; done = 1'b0;
    f_we = 1'b0; f_addr = '0; f_wdata = '0;
    while (!done && halted !== 1'b1 && cyc < 3000) begin
      if (state_dbg == 3'd0 && fetch_cyc[pc_dbg] < 0) fetch_cyc[pc_dbg] = cyc;
      if (bus.dmem_req === 1'b1) begin
        if (wcnt == 0) begin
          f_we = bus.dmem_we; f_addr = bus.dmem_addr; f_wdata = bus.dmem_wdata;
        end else if (f_we !== bus.dmem_we || f_addr !== bus.dmem_addr ||
                     (f_we && f_wdata !== bus.dmem_wdata)) begin
          stable = 1'b0;
        end
        reqcyc++;
        if (abort_req > 0 && reqcyc == abort_req) begin
          reset = 1'b1;
          bus.dmem_ready = 1'b0;
          @(posedge clk);
          #1;
          chk("abort_req", 32'(bus.dmem_req), 32'd0);
          chk("abort_state", 32'(state_dbg), 32'd0);
          chk("abort_pc", 32'(pc_dbg), 32'd0);
          chk("abort_r1", 32'(dut.regs[1]), 32'd0);
          sb.delete();
          done = 1'b1;
        end else begin
          bus.dmem_ready = (wcnt == wait_cfg);
          bus.dmem_rdata = bus.dmem_ready ? ld_val : 8'h11;
          if (bus.dmem_ready) begin
            chk("txn_stable", 32'(stable), 32'd1);
            if (sb.size() == 0) begin
              n_cmp++; n_bad++;
              $display("FAIL sb_unexpected: got we=%0d addr=%0h, expected no access",
                       bus.dmem_we, bus.dmem_addr);
            end else begin
              e = sb.pop_front();
              chk("txn_we", 32'(bus.dmem_we), 32'(e.we));
              chk("txn_addr", 32'(bus.dmem_addr), 32'(e.addr));
              if (e.we) chk("txn_wdata", 32'(bus.dmem_wdata), 32'(e.data));
            end
          end
          wcnt++;
        end
      end else begin
        bus.dmem_ready = idle_ready;
        bus.dmem_rdata = 8'h22;
        wcnt = 0;
        stable = 1'b1;
      end
      if (!done) begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!done) begin
      chk("halt_reached", 32'(halted), 32'd1);
      chk("halt_state", 32'(state_dbg), 32'd5);
      p = pc_dbg;
      bad = 1'b0;
      repeat (100) begin
        @(negedge clk);
        if (pc_dbg !== p || bus.dmem_req !== 1'b0 || state_dbg !== 3'd5 || halted !== 1'b1)
          bad = 1'b1;
      end
      chk("halt_hold", 32'(bad), 32'd0);
      chk("sb_empty", 32'(sb.size()), 32'd0);
    end
  endtask

  alu_vec_t vecs [8];

  initial begin
    vecs[0] = '{op: 4'h2, x: 8'h05, y: 8'h07, res: 8'h0C, c: 1'b0, z: 1'b0, c_care: 1'b1};
    vecs[1] = '{op: 4'h3, x: 8'h05, y: 8'h07, res: 8'hFE, c: 1'b1, z: 1'b0, c_care: 1'b1};
    vecs[2] = '{op: 4'h6, x: 8'h05, y: 8'h05, res: 8'h00, c: 1'b0, z: 1'b1, c_care: 1'b0};
    vecs[3] = '{op: 4'h2, x: 8'hFF, y: 8'h01, res: 8'h00, c: 1'b1, z: 1'b1, c_care: 1'b1};
    vecs[4] = '{op: 4'h4, x: 8'hF0, y: 8'h3C, res: 8'h30, c: 1'b0, z: 1'b0, c_care: 1'b0};
    vecs[5] = '{op: 4'h5, x: 8'h00, y: 8'h00, res: 8'h00, c: 1'b0, z: 1'b1, c_care: 1'b0};
    vecs[6] = '{op: 4'h3, x: 8'h07, y: 8'h07, res: 8'h00, c: 1'b0, z: 1'b1, c_care: 1'b1};
    vecs[7] = '{op: 4'h3, x: 8'h00, y: 8'h01, res: 8'hFF, c: 1'b1, z: 1'b0, c_care: 1'b1};
    ld_val = 8'hA5;

    // ALU table: LDI R1,x; LDI R2,y; op R3,R1,R2; ST R3,[R0]; HALT
    for (int i = 0; i < 8; i++) begin
      clear_prog();
      prog[0] = {4'h1, 4'h1, vecs[i].x};
      prog[1] = {4'h1, 4'h2, vecs[i].y};
      prog[2] = {vecs[i].op, 4'h3, 4'h1, 4'h2};
      prog[3] = 16'h8300;
      push_txn(1'b1, 8'h00, vecs[i].res);
      run_prog(0, 1'b0, 0);
      chk("alu_zero", 32'(dut.flag_z), 32'(vecs[i].z));
      if (vecs[i].c_care) chk("alu_carry", 32'(dut.flag_c), 32'(vecs[i].c));
      if (i == 0) begin
        chk("fetch0_cyc", 32'(fetch_cyc[0]), 32'd0);
        chk("fetch1_cyc", 32'(fetch_cyc[1]), 32'd5);
        chk("fetch2_cyc", 32'(fetch_cyc[2]), 32'd10);
        chk("add_wb_done", 32'(fetch_cyc[3]), 32'd15);
      end
    end

    // Load with 3 stall cycles; ready held high while idle must be ignored
    clear_prog();
    prog[0] = 16'h1105;
    prog[1] = 16'h7610;
    prog[2] = 16'h8600;
    push_txn(1'b0, 8'h05, 8'h00);
    push_txn(1'b1, 8'h00, 8'hA5);
    run_prog(3, 1'b1, 0);
    chk("ld_cycles", 32'(fetch_cyc[2] - fetch_cyc[1]), 32'd8);

    // Branches and jump with pc wrap
    clear_prog();
    prog[0] = 16'h1105;
    prog[1] = 16'h1700;
    prog[2] = 16'hA004;
    prog[3] = 16'hA006;
    prog[4] = 16'h97FE;
    prog[5] = 16'h8100;
    prog[6] = 16'h91FE;
    prog[7] = 16'h8700;
    prog[8] = 16'hA0FF;
    push_txn(1'b1, 8'h00, 8'h00);
    run_prog(0, 1'b0, 0);
    chk("beqz_taken", 32'(fetch_cyc[3] - fetch_cyc[4]), 32'd5);
    chk("beqz_skip", 32'(fetch_cyc[5]), 32'hFFFF_FFFF);
    chk("beqz_not_taken", 32'(fetch_cyc[7] - fetch_cyc[6]), 32'd5);
    chk("jmp_ff", 32'(fetch_cyc[255] - fetch_cyc[8]), 32'd5);
    chk("pc_wrap", 32'(pc_dbg), 32'd0);

    // R0 reads zero, rd==rs==rt, illegal opcode as NOP
    clear_prog();
    prog[0] = 16'h1055;
    prog[1] = 16'h1121;
    prog[2] = 16'h8100;
    prog[3] = 16'h8010;
    prog[4] = 16'h1203;
    prog[5] = 16'h2222;
    prog[6] = 16'h8200;
    prog[7] = 16'hB123;
    prog[8] = 16'h8200;
    push_txn(1'b1, 8'h00, 8'h21);
    push_txn(1'b1, 8'h21, 8'h00);
    push_txn(1'b1, 8'h00, 8'h06);
    push_txn(1'b1, 8'h00, 8'h06);
    run_prog(1, 1'b1, 0);
    chk("r0_zero", 32'(dut.regs[0]), 32'd0);

    // Reset during a long store stall
    clear_prog();
    prog[0] = 16'h1109;
    prog[1] = 16'h8119;
    push_txn(1'b1, 8'h09, 8'h09);
    run_prog(100, 1'b0, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cpu_core_mc.md
Name: cpu_core_mc

Overview:
Parametrised multi-cycle CPU core. It executes a 16-bit fixed-format ISA through the FETCH/DECODE/EXECUTE/MEM/WB sequence and adds a HALT state.
It fetches from an external instruction port and performs loads and stores over a stallable data-memory handshake. It holds a 16-entry register file and exposes debug state for the board top.

Parameters:
DATA_W, 8, register/ALU/data-memory word width (>=8)
PC_W, 8, program counter and instruction address width (1..12)
DADDR_W, 8, data-memory address width (<=DATA_W)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
imem_addr  out  PC_W  instruction address, equals pc
imem_data  in  16  instruction word, combinational read, sampled in FETCH
dmem_req  out  1  data access request, high only in MEM for LD/ST
dmem_we  out  1  1=store, 0=load; valid while dmem_req
dmem_addr  out  DADDR_W  R[rs][DADDR_W-1:0]
dmem_wdata  out  DATA_W  store data R[rd]
dmem_rdata  in  DATA_W  load data, sampled in the cycle dmem_ready=1
dmem_ready  in  1  completes the access in the current cycle
halted  out  1  high while in HALT
state_dbg  out  3  FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, HALT=5
pc_dbg  out  PC_W  pc
ir_dbg  out  16  ir

Behaviour:
- Reset values: state FETCH, pc 0, ir 0, R0..R15 0, zero/carry flags 0, halted 0, dmem_req 0.
- All outputs are decoded from registered state/ir/regs. In the cycle after the reset edge, dmem_req=0.
- Encoding: op=ir[15:12], rd=ir[11:8], rs=ir[7:4], rt=ir[3:0], imm8=ir[7:0].
- FETCH: ir<=imem_data; pc<=pc+1 (mod 2^PC_W). Next state DECODE.
- DECODE: reads operands. op=F goes to HALT; every other op goes to EXECUTE.
- EXECUTE: ALU result is latched.
  - Branch/jump updates pc here and overrides the FETCH increment.
  - Next state MEM.
- MEM:
  - Non-LD/ST: one cycle, then WB.
  - LD/ST: dmem_req=1 with addr/we/wdata held stable until the cycle dmem_ready=1, then WB.
  - dmem_ready outside a request is ignored.
- WB: writes rd if the op writes a register. Next state FETCH.
- CPI: 5, plus wait cycles on LD/ST.
- Ops:
  - 0 NOP.
  - 1 LDI: rd=zext(imm8).
  - 2 ADD: rd=rs+rt.
  - 3 SUB: rd=rs-rt.
  - 4 AND, 5 OR, 6 XOR: rd=rs op rt.
  - 7 LD: rd=mem[R[rs]].
  - 8 ST: mem[R[rs]]=R[rd].
  - 9 BEQZ: if R[rd]==0, pc=pc+sext(imm8). pc is already incremented; result wraps mod 2^PC_W.
  - A JMP: pc=ir[PC_W-1:0].
  - F HALT.
  - B-E are illegal and execute as NOP.
- Arithmetic: results truncate to DATA_W.
  - ADD: carry = carry-out.
  - SUB: carry = borrow (1 when rs<rt, unsigned).
  - zero = (result==0).
  - Flags update only in the WB of ops 2-6.
- R0 reads as 0. Writes to R0 are discarded.
- HALT: absorbing. pc/ir/regs frozen, halted=1, exits only on reset.
- Reset during a MEM stall: abandons the access with no register write; state returns to FETCH.
- rd==rs==rt is legal: operands are read before write-back.

Optional Feature:
- Macro CPU_TRACE_EN.
- When defined, three extra output ports exist:
  - retire_valid (1): one-cycle pulse in WB.
  - retire_pc (PC_W): address of the retiring instruction.
  - retire_ir (16): the retiring instruction word.
- With the macro defined, the core stores the fetch address in a PC_W register at FETCH.
- When the macro is undefined, these ports and the register are absent; all other behaviour is identical.

Test Plan:
- Reset, then LDI R1,5; LDI R2,7; ADD R3,R1,R2 -> R3=0x0C, carry=0; imem_addr visits 0,1,2; WB of ADD occurs 15 cycles after reset release.
- SUB R4,R1,R2 (5-7) -> R4=0xFE, carry=1, zero=0. XOR R5,R1,R1 -> R5=0, zero=1.
- LD R6,[R1] with dmem_ready low for 3 cycles -> dmem_req=1 and dmem_addr=0x05 stable for 4 cycles; R6=dmem_rdata from the ready cycle; instruction takes 8 cycles total.
- LDI R7,0; BEQZ R7,0xFE at pc 4 -> pc=3 (taken backward). BEQZ R1,0xFE -> pc=5 (not taken). JMP 0x0FF with PC_W=8 -> pc=0xFF; next FETCH increments pc to 0x00 (wrap).
- LDI R0,0x55, then ST with rs=0 -> dmem_addr=0 (R0 reads 0). HALT -> halted=1, state_dbg=5, pc stable for 100 cycles, no dmem_req.
- Assert reset during a ST stall -> next cycle dmem_req=0, state_dbg=0, pc=0, regs=0.
